// File: rtl/axis_to_axi4_wr_pkg.sv
// Shared types for the AXI-Stream to AXI4 write-burst converter.
//   fsm_t            : converter state encoding
//   RESP_OKAY/SLVERR : AXI B-channel response encodings
package axis_to_axi4_wr_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SEND_A = 3'd1,
    SEND_D = 3'd2,
    DRAIN  = 3'd3,
    WAIT_B = 3'd4,
    DONE   = 3'd5
  } fsm_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

endpackage

// File: rtl/axi_infs.sv
// Bus interfaces used by the converter.
//   axi_stream_inf : tvalid/tready/tdata/tlast; modports slaver, master
//   axi_inf        : AXI4 write channels (AW, W, B); modports master_wr, slave_wr
//                    awlen is LSIZE wide; narrower command lengths are zero-extended.
interface axi_stream_inf #(parameter int DSIZE = 32);
  logic             tvalid;
  logic             tready;
  logic [DSIZE-1:0] tdata;
  logic             tlast;
  modport slaver (input tvalid, tdata, tlast, output tready);
  modport master (output tvalid, tdata, tlast, input tready);
endinterface

interface axi_inf #(
  parameter int ASIZE  = 32,
  parameter int DSIZE  = 32,
  parameter int IDSIZE = 4,
  parameter int LSIZE  = 16
);
  logic              awvalid;
  logic              awready;
  logic [ASIZE-1:0]  awaddr;
  logic [LSIZE-1:0]  awlen;
  logic [IDSIZE-1:0] awid;
  logic              wvalid;
  logic              wready;
  logic [DSIZE-1:0]  wdata;
  logic              wlast;
  logic              bvalid;
  logic              bready;
  logic [1:0]        bresp;
  modport master_wr (output awvalid, awaddr, awlen, awid, input awready,
                     output wvalid, wdata, wlast, input wready,
                     input bvalid, bresp, output bready);
  modport slave_wr  (input awvalid, awaddr, awlen, awid, output awready,
                     input wvalid, wdata, wlast, output wready,
                     output bvalid, bresp, input bready);
endinterface

// File: rtl/axis_beat_counter.sv
// Beat counter for one W burst.
//   clr        : restart count (AW handshake, i.e. entry to the data phase)
//   beat       : W handshake this cycle
//   tlast, len : stream tlast and captured beats-minus-1
//   wlast      : current beat is the last of the burst (count == len)
//   early_last : tlast seen on a non-final beat
//   late_last  : final beat accepted without tlast
module axis_beat_counter #(
  parameter int LSIZE = 16
) (
  input  logic             clock,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             beat,
  input  logic             tlast,
  input  logic [LSIZE-1:0] len,
  output logic             wlast,
  output logic             early_last,
  output logic             late_last
);

  logic [LSIZE-1:0] beat_cnt_q, beat_cnt_d;

  // Count stops mattering once wlast is taken, so wrapping past all-ones
  // after the final beat of a maximum-length burst is harmless.
  always_comb begin
    beat_cnt_d = beat_cnt_q;
    if (clr)       beat_cnt_d = '0;
    else if (beat) beat_cnt_d = beat_cnt_q + LSIZE'(1);
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) beat_cnt_q <= '0;
    else        beat_cnt_q <= beat_cnt_d;
  end

  assign wlast      = (beat_cnt_q == len);
  assign early_last = beat && tlast && !wlast;
  assign late_last  = beat && wlast && !tlast;

endmodule

// File: rtl/axis_to_axi4_wr.sv
// Turns one command (addr, beats-1, id) plus one AXI-Stream packet into a
// single AXI4 write burst, then pulses done_valid with the B response.
//   clock, rst_n           : clock, async active-low reset
//   cmd_*                  : command handshake and fields
//   axis_in (slaver)       : packet data, forwarded as W data
//   axi_out (master_wr)    : AXI4 AW/W/B master
//   done_valid/resp/len_err: completion pulse, captured bresp, length mismatch
// Build option: AXIS_TO_AXI4_WR_LAST_CHECK_EN enables tlast checking, the
// DRAIN state and len_err; otherwise tlast is ignored and len_err is 0.
module axis_to_axi4_wr
  import axis_to_axi4_wr_pkg::*;
#(
  parameter int ASIZE  = 32,
  parameter int LSIZE  = 16,
  parameter int IDSIZE = 4
) (
  input  logic              clock,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [ASIZE-1:0]  cmd_addr,
  input  logic [LSIZE-1:0]  cmd_len,
  input  logic [IDSIZE-1:0] cmd_id,
  axi_stream_inf.slaver     axis_in,
  axi_inf.master_wr         axi_out,
  output logic              done_valid,
  output logic [1:0]        done_resp,
  output logic              len_err
);

  fsm_t              state_q, state_d;
  logic [ASIZE-1:0]  addr_q, addr_d;
  logic [LSIZE-1:0]  len_q, len_d;
  logic [IDSIZE-1:0] id_q, id_d;
  logic              err_q, err_d;
  logic [1:0]        resp_q, resp_d;
  logic              cmd_ready_q, cmd_ready_d;
  logic              awvalid_q, awvalid_d;
  logic              bready_q, bready_d;
  logic              done_valid_q, done_valid_d;

  logic aw_hs, w_hs, cnt_wlast, early_last, late_last;

  assign aw_hs = awvalid_q && axi_out.awready;
  assign w_hs  = (state_q == SEND_D) && axis_in.tvalid && axi_out.wready;

  axis_beat_counter #(.LSIZE(LSIZE)) u_cnt (
    .clock      (clock),
    .rst_n      (rst_n),
    .clr        (aw_hs),
    .beat       (w_hs),
    .tlast      (axis_in.tlast),
    .len        (len_q),
    .wlast      (cnt_wlast),
    .early_last (early_last),
    .late_last  (late_last)
  );

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    len_d   = len_q;
    id_d    = id_q;
    err_d   = err_q;
    resp_d  = resp_q;
    case (state_q)
      IDLE: if (cmd_valid && cmd_ready_q) begin
        addr_d  = cmd_addr;
        len_d   = cmd_len;
        id_d    = cmd_id;
        err_d   = 1'b0;
        state_d = SEND_A;
      end
      SEND_A: if (aw_hs) state_d = SEND_D;
      SEND_D: if (w_hs) begin
`ifdef AXIS_TO_AXI4_WR_LAST_CHECK_EN
        if (early_last || late_last) err_d = 1'b1;
        // Packet longer than the burst: discard its tail before reporting.
        if (cnt_wlast) state_d = late_last ? DRAIN : WAIT_B;
`else
        if (cnt_wlast) state_d = WAIT_B;
`endif
      end
      DRAIN: if (axis_in.tvalid && axis_in.tlast) state_d = WAIT_B;
      WAIT_B: if (axi_out.bvalid && bready_q) begin
        resp_d  = axi_out.bresp;
        state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Handshake-side outputs are registered, decoded from the next state.
    cmd_ready_d  = (state_d == IDLE);
    awvalid_d    = (state_d == SEND_A);
    bready_d     = (state_d == WAIT_B);
    done_valid_d = (state_d == DONE);
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      len_q        <= '0;
      id_q         <= '0;
      err_q        <= 1'b0;
      resp_q       <= '0;
      cmd_ready_q  <= 1'b0;
      awvalid_q    <= 1'b0;
      bready_q     <= 1'b0;
      done_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      len_q        <= len_d;
      id_q         <= id_d;
      err_q        <= err_d;
      resp_q       <= resp_d;
      cmd_ready_q  <= cmd_ready_d;
      awvalid_q    <= awvalid_d;
      bready_q     <= bready_d;
      done_valid_q <= done_valid_d;
    end
  end

  assign cmd_ready  = cmd_ready_q;
  assign done_valid = done_valid_q;
  assign done_resp  = resp_q;
`ifdef AXIS_TO_AXI4_WR_LAST_CHECK_EN
  assign len_err = err_q;
`else
  logic unused_last_chk;
  assign unused_last_chk = early_last ^ late_last ^ err_q;
  assign len_err = 1'b0;
`endif

  assign axi_out.awvalid = awvalid_q;
  assign axi_out.awaddr  = addr_q;
  assign axi_out.awid    = id_q;
  always_comb begin
    axi_out.awlen            = '0;
    axi_out.awlen[LSIZE-1:0] = len_q;
  end

  assign axi_out.wvalid = (state_q == SEND_D) && axis_in.tvalid;
  assign axi_out.wdata  = axis_in.tdata;
  assign axi_out.wlast  = (state_q == SEND_D) && cnt_wlast;
  assign axi_out.bready = bready_q;
  assign axis_in.tready = ((state_q == SEND_D) && axi_out.wready) || (state_q == DRAIN);

endmodule

// File: tb/tb_axis_to_axi4_wr.sv
`timescale 1ns/1ps
module tb_axis_to_axi4_wr;
  import axis_to_axi4_wr_pkg::*;

  localparam int AW = 32, LW = 5, IW = 4, DW = 32;
`ifdef AXIS_TO_AXI4_WR_LAST_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic clock = 1'b0;
  logic rst_n = 1'b1;
  always #5 clock = ~clock;

  logic          cmd_valid = 1'b0, cmd_ready;
  logic [AW-1:0] cmd_addr = '0;
  logic [LW-1:0] cmd_len = '0;
  logic [IW-1:0] cmd_id = '0;
  logic          done_valid, len_err;
  logic [1:0]    done_resp;

  axi_stream_inf #(.DSIZE(DW)) axis ();
  axi_inf #(.ASIZE(AW), .DSIZE(DW), .IDSIZE(IW), .LSIZE(8)) axi ();

  axis_to_axi4_wr #(.ASIZE(AW), .LSIZE(LW), .IDSIZE(IW)) dut (
    .clock(clock), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
    .cmd_len(cmd_len), .cmd_id(cmd_id),
    .axis_in(axis), .axi_out(axi),
    .done_valid(done_valid), .done_resp(done_resp), .len_err(len_err)
  );

  typedef struct { logic [DW-1:0] data; logic last; } beat_t;
  typedef struct { logic [AW-1:0] addr; logic [LW-1:0] len; logic [IW-1:0] id; } cmd_t;
  typedef struct { logic [1:0] resp; logic err; logic drain; } done_t;
  typedef struct {
    logic [AW-1:0] addr; logic [LW-1:0] len; logic [IW-1:0] id; int pkt;
    logic [1:0] bresp; bit wtog; int bdly; logic exp_err;
  } vec_t;

  beat_t src_q[$], mdl_q[$], exp_w[$];
  cmd_t  cmd_q[$], exp_aw[$];
  done_t exp_done[$];
  logic [1:0] bresp_q[$];
  int    bdly_q[$];

  int n_chk = 0, n_pass = 0;
  int cyc = 0, seq = 0;
  int cmd_cyc = -10, aw_cyc = -10, lastw_cyc = -10, b_cyc = -10, rst_rel_cyc = -10;
  bit wtog = 0, b_pend = 0, do_release = 0, after_rst = 0;
  bit prev_aw = 0, prev_crdy = 0, prev_brdy = 0;
  int b_tmr = 0;
  logic [1:0] b_cur = '0;
  vec_t vecs[6];

  function automatic void check(string nm, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
  endfunction

  task automatic push_pkt(int n);
    beat_t b;
    for (int i = 0; i < n; i++) begin
      b.data = DW'(32'hA500_0000 + seq);
      b.last = (i == n - 1);
      seq++;
      src_q.push_back(b);
      mdl_q.push_back(b);
    end
  endtask

  // Builds the expected W beats from the stream model: the next len+1 beats,
  // wlast only on the final one; with checking on, a missing tlast on that
  // beat means the rest of the packet is discarded.
  task automatic push_cmd(logic [AW-1:0] a, logic [LW-1:0] l, logic [IW-1:0] id,
                          logic [1:0] br, int bd, logic err);
    cmd_t c; beat_t b, w; done_t d;
    logic lastb;
    c.addr = a; c.len = l; c.id = id;
    cmd_q.push_back(c); exp_aw.push_back(c);
    lastb = 1'b1;
    for (int i = 0; i <= int'(l); i++) begin
      if (mdl_q.size() == 0) break;
      b = mdl_q.pop_front();
      w.data = b.data; w.last = (i == int'(l));
      exp_w.push_back(w);
      lastb = b.last;
    end
    d.drain = CHK && !lastb;
    if (d.drain) begin
      while (mdl_q.size() > 0) begin
        b = mdl_q.pop_front();
        if (b.last) break;
      end
    end
    d.resp = br; d.err = err;
    exp_done.push_back(d); bresp_q.push_back(br); bdly_q.push_back(bd);
  endtask

  task automatic cycle();
    beat_t b; cmd_t c; done_t d;
    @(negedge clock);
    if (do_release) begin
      rst_n = 1'b1; do_release = 0; rst_rel_cyc = cyc; after_rst = 1;
    end
    cmd_valid = (cmd_q.size() > 0);
    if (cmd_valid) begin
      cmd_addr = cmd_q[0].addr; cmd_len = cmd_q[0].len; cmd_id = cmd_q[0].id;
    end
    axis.tvalid = (src_q.size() > 0);
    if (axis.tvalid) begin axis.tdata = src_q[0].data; axis.tlast = src_q[0].last; end
    axi.awready = wtog ? cyc[1] : 1'b1;
    axi.wready  = wtog ? cyc[0] : 1'b1;
    if (!b_pend) axi.bvalid = 1'b0;
    else if (!axi.bvalid) begin
      if (b_tmr == 0) begin axi.bvalid = 1'b1; axi.bresp = b_cur; end
      else b_tmr--;
    end
    #3;
    if (rst_n) begin
      if (axi.awvalid && !prev_aw) check("aw_rise_latency", cyc, cmd_cyc + 1);
      if (cmd_valid && cmd_ready) begin void'(cmd_q.pop_front()); cmd_cyc = cyc; end
      if (axi.awvalid && axi.awready) begin
        aw_cyc = cyc;
        if (exp_aw.size() == 0) check("aw_unexpected", axi.awvalid, 0);
        else begin
          c = exp_aw.pop_front();
          check("awaddr", axi.awaddr, c.addr);
          check("awlen", axi.awlen, 64'(c.len));
          check("awid", axi.awid, c.id);
        end
      end
      if (cyc == aw_cyc + 1) check("w_offered_after_aw", axi.wvalid, axis.tvalid);
      if (axi.wvalid) check("tready_follows_wready", axis.tready, axi.wready);
      if (axi.wvalid && axi.wready) begin
        if (exp_w.size() == 0) check("w_unexpected", axi.wvalid, 0);
        else begin
          b = exp_w.pop_front();
          check("wdata", axi.wdata, b.data);
          check("wlast", axi.wlast, b.last);
          if (axi.wlast) begin
            lastw_cyc = cyc; b_pend = 1;
            b_cur = bresp_q.pop_front(); b_tmr = bdly_q.pop_front();
          end
        end
      end
      if (axis.tvalid && axis.tready) void'(src_q.pop_front());
      if (axi.bready && !prev_brdy && exp_done.size() > 0 && !exp_done[0].drain)
        check("bready_latency", cyc, lastw_cyc + 1);
      if (axi.bvalid && axi.bready) begin b_pend = 0; b_cyc = cyc; end
      if (done_valid) begin
        if (exp_done.size() == 0) check("done_unexpected", done_valid, 0);
        else begin
          d = exp_done.pop_front();
          check("done_resp", done_resp, d.resp);
          check("len_err", len_err, d.err);
          check("done_latency", cyc, b_cyc + 1);
        end
      end
      if (cmd_ready && !prev_crdy) begin
        if (after_rst) check("cmd_ready_after_reset", cyc, rst_rel_cyc + 1);
        else check("cmd_ready_after_done", cyc, b_cyc + 2);
        after_rst = 0;
      end
      prev_aw = axi.awvalid; prev_crdy = cmd_ready; prev_brdy = axi.bready;
    end
    cyc++;
  endtask

  task automatic run_until_idle(int budget);
    int n = 0;
    while ((cmd_q.size() > 0 || exp_w.size() > 0 || exp_done.size() > 0 || b_pend) && n < budget) begin
      cycle(); n++;
    end
    check("burst_completed_in_budget", exp_done.size(), 0);
    repeat (2) cycle();
  endtask

  task automatic check_reset_vals(string tag);
    check({tag, "_cmd_ready"}, cmd_ready, 0);
    check({tag, "_awvalid"}, axi.awvalid, 0);
    check({tag, "_bready"}, axi.bready, 0);
    check({tag, "_done_valid"}, done_valid, 0);
    check({tag, "_done_resp"}, done_resp, 0);
    check({tag, "_len_err"}, len_err, 0);
    check({tag, "_wvalid"}, axi.wvalid, 0);
    check({tag, "_tready"}, axis.tready, 0);
  endtask

  initial begin
    axis.tvalid = 0; axis.tdata = '0; axis.tlast = 0;
    axi.awready = 0; axi.wready = 0; axi.bvalid = 0; axi.bresp = '0;
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clock);
    #3 check_reset_vals("reset");
    do_release = 1;
    repeat (3) cycle();

    vecs[0] = '{32'h0000_1000, 5'd7, 4'd3, 8, RESP_OKAY,   1'b0, 0,  1'b0};
    vecs[1] = '{32'h0000_2000, 5'd0, 4'd5, 1, RESP_OKAY,   1'b0, 0,  1'b0};
    vecs[2] = '{32'h0000_3000, 5'd5, 4'd9, 6, RESP_SLVERR, 1'b1, 20, 1'b0};
    vecs[3] = '{32'hFFFF_FFF0, 5'd2, 4'hF, 3, 2'b01,       1'b1, 2,  1'b0};
    vecs[4] = '{32'h0000_4000, 5'd3, 4'd6, 6, RESP_OKAY,   1'b0, 0,  CHK};
    vecs[5] = '{32'h0000_4800, 5'd1, 4'd4, CHK ? 2 : 0, RESP_SLVERR, 1'b0, 1, 1'b0};
    for (int i = 0; i < 6; i++) begin
      wtog = vecs[i].wtog;
      push_pkt(vecs[i].pkt);
      push_cmd(vecs[i].addr, vecs[i].len, vecs[i].id, vecs[i].bresp, vecs[i].bdly, vecs[i].exp_err);
      run_until_idle(300);
    end
    wtog = 0;

    // Early tlast: a short packet followed by another fills one burst.
    push_pkt(2); push_pkt(2);
    push_cmd(32'h0000_6000, 5'd3, 4'd7, RESP_SLVERR, 3, CHK);
    run_until_idle(300);

    // Maximum length: all-ones cmd_len gives 2^LW beats.
    push_pkt(32);
    push_cmd(32'h0000_7000, 5'h1F, 4'd1, RESP_OKAY, 0, 1'b0);
    run_until_idle(300);

    // Reset in the middle of the data phase.
    push_pkt(8);
    push_cmd(32'h0000_5000, 5'd7, 4'd2, RESP_OKAY, 0, 1'b0);
    for (int n = 0; n < 50 && exp_w.size() > 5; n++) cycle();
    check("reached_data_phase", exp_w.size(), 5);
    @(negedge clock);
    rst_n = 1'b0;
    #3 check_reset_vals("midburst_reset");
    src_q.delete(); mdl_q.delete(); exp_w.delete(); cmd_q.delete(); exp_aw.delete();
    exp_done.delete(); bresp_q.delete(); bdly_q.delete();
    b_pend = 0; prev_aw = 0; prev_crdy = 0; prev_brdy = 0;
    cycle();
    do_release = 1;
    repeat (2) cycle();
    push_pkt(4);
    push_cmd(32'h0000_8000, 5'd3, 4'd8, RESP_SLVERR, 1, 1'b0);
    run_until_idle(300);

    check("stream_fully_consumed", src_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
